// File: rtl/pat_pkg.sv
// Shared definitions for the X-line sequencer and the external X-step counter:
// step codes, the code-to-delta mapping both sides must agree on, and the
// sequencer FSM states.
package pat_pkg;

    localparam int XW_DEFAULT = 12;
    localparam int LW_DEFAULT = 8;

    // Counter step select codes.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        ONE   = 2'b01,
        FOUR  = 2'b10,
        EIGHT = 2'b11
    } xmode_e;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        LINE_END = 3'd3,
        DONE     = 3'd4
    } seq_state_e;

    // Step size selected by an Xmode code; the counter adds this to LoadVal.
    function automatic logic [3:0] xmode_delta(input logic [1:0] code);
        logic [3:0] d;
        case (code)
            2'b00:   d = 4'd0;
            2'b01:   d = 4'd1;
            2'b10:   d = 4'd4;
            default: d = 4'd8;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pat_x_sequencer_if.sv
// Pixel stream from the X-line sequencer to the downstream pixel consumer.
//
// Handshake: a beat transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. While pix_valid is 1 and pix_ready is 0 the master
// holds pix_x and pix_last stable. pix_last is meaningful only with pix_valid.
interface pat_x_sequencer_if #(
    parameter int XW = pat_pkg::XW_DEFAULT
);
    logic [XW-1:0] pix_x;
    logic          pix_valid;
    logic          pix_last;
    logic          pix_ready;

    modport master (output pix_x, output pix_valid, output pix_last, input pix_ready);
    modport slave  (input pix_x, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/pat_x_sequencer.sv
// Line-scan controller: steers the external 12-bit X-step counter through
// x_start..x_end for num_lines lines and streams the counter output as pixel
// X coordinates. The counter sits beside this block; its registered output
// comes back on cnt_out one cycle after cnt_enb/Xmode/LoadVal are driven.
//
// Build option: define PAT_XSEQ_STALL_CNT_EN to enable the saturating
// stall_cnt counter; otherwise stall_cnt is tied to 0.
module pat_x_sequencer
    import pat_pkg::*;
#(
    parameter int XW = XW_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [XW-1:0]          x_start,
    input  logic [XW-1:0]          x_end,
    input  logic [1:0]             step_mode,
    input  logic [LW-1:0]          num_lines,
    output logic                   cnt_enb,
    output logic [1:0]             Xmode,
    output logic [XW-1:0]          LoadVal,
    input  logic [XW-1:0]          cnt_out,
    pat_x_sequencer_if.master      pix_if,
    output logic [LW-1:0]          line_idx,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            stall_cnt,
    output logic [2:0]             dbg_state
);

    localparam int XW1 = XW + 1;

    seq_state_e    state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic          done_q, done_d;

    logic [XW-1:0] xs_q, xe_q;
    xmode_e        mode_q;
    logic [LW-1:0] nl_q;

    logic          start_acc;
    logic [XW:0]   nxt_x;
    logic          last_px;
    logic          pix_valid_c;
    logic          pix_last_c;

    assign start_acc = (state_q == IDLE) && start && !abort;

    // One extra bit on the next-X sum so a step past the top of the range is
    // seen as larger than any x_end instead of wrapping to a small value.
    assign nxt_x   = {1'b0, cnt_out} + XW1'(xmode_delta(mode_q));
    assign last_px = (mode_q == ZERO) || (nxt_x > {1'b0, xe_q}) || (cnt_out >= xe_q);

    // FSM state, line index and done flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    // Frame configuration is latched only when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q   <= '0;
            xe_q   <= '0;
            mode_q <= ZERO;
            nl_q   <= '0;
        end else if (start_acc) begin
            xs_q   <= x_start;
            xe_q   <= x_end;
            mode_q <= xmode_e'(step_mode);
            nl_q   <= num_lines;
        end
    end

    // Next-state logic plus counter and pixel-stream controls.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        cnt_enb     = 1'b0;
        Xmode       = ZERO;
        LoadVal     = '0;
        pix_valid_c = 1'b0;
        pix_last_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    line_d  = '0;
                    state_d = (num_lines == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // Seed the counter with x_start; it appears on cnt_out in RUN.
                cnt_enb = 1'b1;
                LoadVal = xs_q;
                Xmode   = ZERO;
                state_d = RUN;
            end
            RUN: begin
                pix_valid_c = 1'b1;
                pix_last_c  = last_px;
                if (!pix_if.pix_ready) begin
                    // Reload the current value with a zero step so it holds.
                    cnt_enb = 1'b1;
                    LoadVal = cnt_out;
                    Xmode   = ZERO;
                end else if (!last_px) begin
                    cnt_enb = 1'b1;
                    LoadVal = cnt_out;
                    Xmode   = mode_q;
                end else begin
                    state_d = LINE_END;
                end
            end
            LINE_END: begin
                // Counter enable low here clears the counter between lines.
                if (line_q == nl_q - LW'(1)) begin
                    state_d = DONE;
                end else begin
                    line_d  = line_q + LW'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            line_d  = '0;
        end

        done_d = (state_d == DONE);
    end

    assign pix_if.pix_x     = cnt_out;
    assign pix_if.pix_valid = pix_valid_c;
    assign pix_if.pix_last  = pix_last_c;

    assign line_idx  = line_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

`ifdef PAT_XSEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count cycles where a pixel is offered but not taken; saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && !pix_if.pix_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pat_x_sequencer.sv
// Self-checking bench for pat_x_sequencer: a behavioural X-step counter,
// a table of directed frames, hand-written stall/abort/reset sequences and
// randomized frames checked against a list-based reference model.
module tb_pat_x_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] x_start = '0;
  logic [11:0] x_end = '0;
  logic [1:0]  step_mode = '0;
  logic [7:0]  num_lines = '0;
  logic [11:0] cnt_out;
  logic        cnt_enb;
  logic [1:0]  Xmode;
  logic [11:0] LoadVal;
  logic [7:0]  line_idx;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;
  logic [2:0]  dbg_state;

  pat_x_sequencer_if #(.XW(12)) pix_if ();

  pat_x_sequencer #(.XW(12), .LW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .x_start   (x_start),
    .x_end     (x_end),
    .step_mode (step_mode),
    .num_lines (num_lines),
    .cnt_enb   (cnt_enb),
    .Xmode     (Xmode),
    .LoadVal   (LoadVal),
    .cnt_out   (cnt_out),
    .pix_if    (pix_if.master),
    .line_idx  (line_idx),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External X-step counter: one-cycle latency, clears when not enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_out <= '0;
    else if (cnt_enb) begin
      case (Xmode)
        2'b00:   cnt_out <= LoadVal;
        2'b01:   cnt_out <= LoadVal + 12'd1;
        2'b10:   cnt_out <= LoadVal + 12'd4;
        default: cnt_out <= LoadVal + 12'd8;
      endcase
    end else cnt_out <= '0;
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [20:0] exp_q[$];   // {line, last, x}
  logic [20:0] obs_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: list the X values of one line from the stepping rules.
  task automatic model_line(input int xs, input int xe, input int md, input int line);
    int x, d;
    bit lst;
    d = (md == 0) ? 0 : (md == 1) ? 1 : (md == 2) ? 4 : 8;
    x = xs;
    forever begin
      lst = (d == 0) || (x >= xe) || (x + d > xe);
      exp_q.push_back({8'(line), lst, 12'(x)});
      if (lst) break;
      x += d;
    end
  endtask

  // ---------------- driver + monitor for one frame ----------------
  task automatic run_frame(input string name, input logic [11:0] xs, input logic [11:0] xe,
                           input logic [1:0] md, input logic [7:0] nl, input int rdy_pct,
                           input bit use_model);
    int cyc, first_v, done_cyc, done_n, last_acc, prev_acc, stalls, exp_stall;
    int hold_err, le_err, busy_err, tput_err, mis, first_mis, n;
    bit prev_stall, prev_last_acc, prev_acc_last;
    logic [11:0] prev_x;

    if (use_model) begin
      exp_q.delete();
      for (int l = 0; l < int'(nl); l++) model_line(int'(xs), int'(xe), int'(md), l);
    end
    obs_q.delete();
    first_v = -1; done_cyc = -1; done_n = 0; last_acc = -1; prev_acc = -1; stalls = 0;
    hold_err = 0; le_err = 0; busy_err = 0; tput_err = 0;
    prev_stall = 0; prev_last_acc = 0; prev_acc_last = 0; prev_x = '0;

    @(negedge clk);
    x_start = xs; x_end = xe; step_mode = md; num_lines = nl; start = 1'b1;
    pix_if.pix_ready = ($urandom_range(1, 100) <= rdy_pct);

    for (cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start = busy && !done && ($urandom_range(0, 9) == 0);
      x_start = 12'($urandom); x_end = 12'($urandom);
      step_mode = 2'($urandom); num_lines = 8'($urandom);
      pix_if.pix_ready = ($urandom_range(1, 100) <= rdy_pct);
      #1;
      if (done_cyc >= 0) begin
        if (busy || done) busy_err++;
        break;
      end
      if (pix_if.pix_valid && first_v < 0) first_v = cyc;
      if (prev_stall && !(pix_if.pix_valid && pix_if.pix_x == prev_x)) hold_err++;
      if (prev_last_acc && (cnt_enb || pix_if.pix_valid)) le_err++;
      if (!busy) busy_err++;
      prev_stall = 0; prev_last_acc = 0;
      if (pix_if.pix_valid && !pix_if.pix_ready) begin
        stalls++;
        prev_stall = 1;
        prev_x = pix_if.pix_x;
        if (!cnt_enb || Xmode != 2'b00 || LoadVal != pix_if.pix_x) hold_err++;
      end
      if (pix_if.pix_valid && pix_if.pix_ready) begin
        obs_q.push_back({line_idx, pix_if.pix_last, pix_if.pix_x});
        if (prev_acc >= 0 && !prev_acc_last && cyc != prev_acc + 1) tput_err++;
        prev_acc = cyc;
        prev_acc_last = pix_if.pix_last;
        prev_last_acc = pix_if.pix_last;
        last_acc = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    pix_if.pix_ready = 1'b1;

    check({name, " done seen"}, int'(done_cyc >= 0), 1);
    check({name, " done count"}, done_n, 1);
    check({name, " pixel count"}, obs_q.size(), exp_q.size());
    mis = 0; first_mis = -1;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        mis++;
        if (first_mis < 0) first_mis = i;
      end
    end
    check({name, " pixel sequence"}, mis, 0);
    if (first_mis >= 0)
      $display("  %s first diff at %0d: got {line,last,x}=%h want %h", name, first_mis,
               obs_q[first_mis], exp_q[first_mis]);
    check({name, " stall hold"}, hold_err, 0);
    check({name, " line end bubble"}, le_err, 0);
    check({name, " busy"}, busy_err, 0);
    if (nl != 8'd0) check({name, " first valid cycle"}, first_v, 2);
    else check({name, " empty frame early done"}, int'(first_v < 0 && done_cyc >= 1 && done_cyc <= 2), 1);
    if (rdy_pct >= 100 && nl != 8'd0) begin
      check({name, " throughput"}, tput_err, 0);
      check({name, " done after last pixel"}, done_cyc - last_acc, 2);
    end
`ifdef PAT_XSEQ_STALL_CNT_EN
    exp_stall = stalls;
`else
    exp_stall = 0;
`endif
    check({name, " stall_cnt"}, int'(stall_cnt), exp_stall);
  endtask

  // Start a 10..30 step-4 frame with ready high and wait until x=target is shown.
  task automatic start_and_wait_x(input logic [11:0] target, output bit found);
    found = 0;
    @(negedge clk);
    x_start = 12'd10; x_end = 12'd30; step_mode = 2'b10; num_lines = 8'd1;
    start = 1'b1; pix_if.pix_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (pix_if.pix_valid && pix_if.pix_x == target) begin
        found = 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [11:0] xs;
    logic [11:0] xe;
    logic [1:0]  md;
    logic [7:0]  nl;
    int          n;
    logic [11:0] px[6];
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit found;
    int bad;
    logic [11:0] rxs, rxe;

    tbl[0] = '{xs: 12'd10,   xe: 12'd30,   md: 2'b10, nl: 8'd1, n: 6,
               px: '{12'd10, 12'd14, 12'd18, 12'd22, 12'd26, 12'd30}};
    tbl[1] = '{xs: 12'hFF8,  xe: 12'hFFF,  md: 2'b11, nl: 8'd1, n: 1,
               px: '{12'hFF8, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    tbl[2] = '{xs: 12'hFFE,  xe: 12'hFFF,  md: 2'b01, nl: 8'd1, n: 2,
               px: '{12'hFFE, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0}};
    tbl[3] = '{xs: 12'd0,    xe: 12'd8,    md: 2'b11, nl: 8'd3, n: 2,
               px: '{12'd0, 12'd8, 12'h0, 12'h0, 12'h0, 12'h0}};
    tbl[4] = '{xs: 12'd5,    xe: 12'd9,    md: 2'b00, nl: 8'd2, n: 1,
               px: '{12'd5, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    tbl[5] = '{xs: 12'd5,    xe: 12'd9,    md: 2'b01, nl: 8'd0, n: 0,
               px: '{12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    tbl[6] = '{xs: 12'd20,   xe: 12'd10,   md: 2'b01, nl: 8'd2, n: 1,
               px: '{12'd20, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    tbl[7] = '{xs: 12'hFF0,  xe: 12'hFFF,  md: 2'b10, nl: 8'd1, n: 4,
               px: '{12'hFF0, 12'hFF4, 12'hFF8, 12'hFFC, 12'h0, 12'h0}};

    // ---------------- reset ----------------
    pix_if.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset cnt_enb", int'(cnt_enb), 0);
    check("reset LoadVal/Xmode", int'({Xmode, LoadVal}), 0);
    check("reset pix_valid/last", int'({pix_if.pix_valid, pix_if.pix_last}), 0);
    check("reset busy/done", int'({busy, done}), 0);
    check("reset line_idx", int'(line_idx), 0);
    check("reset stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle after reset busy", int'(busy), 0);

    // ---------------- directed table, consumer always ready ----------------
    foreach (tbl[t]) begin
      exp_q.delete();
      for (int l = 0; l < int'(tbl[t].nl); l++)
        for (int i = 0; i < tbl[t].n; i++)
          exp_q.push_back({8'(l), (i == tbl[t].n - 1), tbl[t].px[i]});
      run_frame($sformatf("table%0d", t), tbl[t].xs, tbl[t].xe, tbl[t].md, tbl[t].nl, 100, 0);
    end

    // ---------------- stall for 3 cycles at x=14 ----------------
    start_and_wait_x(12'd10, found);
    check("stall: reached x=10", int'(found), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pix_if.pix_ready = 1'b0;
      #1;
      check("stall: pix_x held", int'(pix_if.pix_x), 14);
      check("stall: valid/cnt_enb", int'({pix_if.pix_valid, cnt_enb}), 3);
      check("stall: Xmode", int'(Xmode), 0);
      check("stall: LoadVal", int'(LoadVal), 14);
    end
    for (int x = 14; x <= 30; x += 4) begin
      @(negedge clk);
      pix_if.pix_ready = 1'b1;
      #1;
      check("resume: pix_x", int'(pix_if.pix_x), x);
      check("resume: valid/last", int'({pix_if.pix_valid, pix_if.pix_last}), (x == 30) ? 3 : 2);
    end
    @(negedge clk); #1;
    check("stall: line end cnt_enb/valid", int'({cnt_enb, pix_if.pix_valid}), 0);
    @(negedge clk); #1;
    check("stall: done", int'(done), 1);
`ifdef PAT_XSEQ_STALL_CNT_EN
    check("stall: stall_cnt", int'(stall_cnt), 3);
`else
    check("stall: stall_cnt", int'(stall_cnt), 0);
`endif
    @(negedge clk); #1;
    check("stall: back to idle", int'({busy, done}), 0);

    // ---------------- abort at x=18 ----------------
    start_and_wait_x(12'd18, found);
    check("abort: reached x=18", int'(found), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort: valid/cnt_enb", int'({pix_if.pix_valid, cnt_enb}), 0);
    check("abort: busy", int'(busy), 0);
    check("abort: line_idx", int'(line_idx), 0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || pix_if.pix_valid || busy) bad++;
      @(negedge clk); #1;
    end
    check("abort: no done afterwards", bad, 0);

    // ---------------- reset mid-line at x=18 ----------------
    start_and_wait_x(12'd18, found);
    check("midreset: reached x=18", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check("midreset: valid/cnt_enb", int'({pix_if.pix_valid, cnt_enb}), 0);
    check("midreset: busy/done", int'({busy, done}), 0);
    check("midreset: LoadVal", int'(LoadVal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("midreset: stall_cnt", int'(stall_cnt), 0);
    check("midreset: idle", int'(busy), 0);

    // ---------------- randomized frames ----------------
    for (int r = 0; r < 40; r++) begin
      rxs = 12'($urandom);
      if ($urandom_range(0, 3) == 0) rxs = 12'hFC0 | 12'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) rxe = 12'($urandom);
      else rxe = ((int'(rxs) + $urandom_range(0, 60)) > 4095) ? 12'hFFF
                 : 12'(int'(rxs) + $urandom_range(0, 60));
      run_frame($sformatf("rand%0d", r), rxs, rxe, 2'($urandom), 8'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(30, 90), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
